reg_file_param: RTL and testbench

- Parametrised register file; successor to the single 32-bit load-enable register.
- Holds DEPTH words of WIDTH bits, with one synchronous write port and two combinational read ports.
- Optional hardwired-zero entry 0 and optional write-to-read bypass.
- Serves as the CPU datapath's architectural register file, feeding the ALU operand muxes.

---
 rtl/reg_file_param.sv | 64 ++++++
 tb/tb_reg_file_param.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_param.sv
// Parametrised register file: DEPTH x WIDTH flops, one synchronous write port,
// two combinational read ports, optional hardwired-zero entry 0 and write bypass.
module reg_file_param #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned DEPTH    = 32,
  parameter int unsigned AW       = 5,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr0,
  output logic [WIDTH-1:0] rdata0,
  input  logic [AW-1:0]    raddr1,
  output logic [WIDTH-1:0] rdata1
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             wr_en_c;

  // An address maps to real storage: in range and not the hardwired-zero entry.
  function automatic logic addr_live(input logic [AW-1:0] a);
    return (32'(a) < DEPTH) && !(ZERO_REG && (a == '0));
  endfunction

  // Read mux for one port; reset, dead addresses and bypass resolved in priority order.
  function automatic logic [WIDTH-1:0] read_port(input logic [AW-1:0] ra);
    logic [WIDTH-1:0] val;
    val = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (ra == AW'(i)) val = mem_q[i];
    end
    if (BYPASS && we && (waddr == ra)) val = wdata;
    if (reset || !addr_live(ra)) val = '0;
    return val;
  endfunction

  // Gating on we first keeps X on waddr/wdata out of the state when idle.
  assign wr_en_c = we && addr_live(waddr);

  always_comb begin
    mem_d = mem_q;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (wr_en_c && (waddr == AW'(i))) mem_d[i] = wdata;
    end
  end

  // Reset takes priority over any coincident write.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  always_comb rdata0 = read_port(raddr0);
  always_comb rdata1 = read_port(raddr1);

endmodule

// File: tb/tb_reg_file_param.sv
// Scoreboard bench for reg_file_param: default, no-bypass and DEPTH=20/WIDTH=16 builds.
module tb_reg_file_param;

  logic        clk;
  logic        rst;
  logic        we_ab;
  logic [4:0]  waddr_ab;
  logic [31:0] wdata_ab;
  logic [4:0]  ra0_ab, ra1_ab;
  logic [31:0] rd0_a, rd1_a, rd0_b, rd1_b;
  logic        we_c;
  logic [4:0]  waddr_c;
  logic [15:0] wdata_c;
  logic [4:0]  ra0_c, ra1_c;
  logic [15:0] rd0_c, rd1_c;

  reg_file_param u_dut_a (
    .clock(clk), .reset(rst), .we(we_ab), .waddr(waddr_ab), .wdata(wdata_ab),
    .raddr0(ra0_ab), .rdata0(rd0_a), .raddr1(ra1_ab), .rdata1(rd1_a)
  );

  reg_file_param #(.BYPASS(1'b0)) u_dut_b (
    .clock(clk), .reset(rst), .we(we_ab), .waddr(waddr_ab), .wdata(wdata_ab),
    .raddr0(ra0_ab), .rdata0(rd0_b), .raddr1(ra1_ab), .rdata1(rd1_b)
  );

  reg_file_param #(.WIDTH(16), .DEPTH(20), .AW(5)) u_dut_c (
    .clock(clk), .reset(rst), .we(we_c), .waddr(waddr_c), .wdata(wdata_c),
    .raddr0(ra0_c), .rdata0(rd0_c), .raddr1(ra1_c), .rdata1(rd1_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    int unsigned sel;
    logic [31:0] exp;
  } sb_t;

  sb_t         sb_q[$];
  logic [31:0] model_ab [32];
  logic [15:0] model_c  [20];
  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] dut_out(input int unsigned sel);
    case (sel)
      0:       return rd0_a;
      1:       return rd1_a;
      2:       return rd0_b;
      3:       return rd1_b;
      4:       return {16'h0, rd0_c};
      default: return {16'h0, rd1_c};
    endcase
  endfunction

  // Reference read for the 32-entry builds (every 5-bit address is in range).
  function automatic logic [31:0] ref_ab(input logic [4:0] ra, input bit byp);
    if (rst) return 32'h0;
    if (ra == 5'd0) return 32'h0;
    if (byp && we_ab && (waddr_ab == ra)) return wdata_ab;
    return model_ab[ra];
  endfunction

  function automatic logic [31:0] ref_c(input logic [4:0] ra);
    if (rst) return 32'h0;
    if (ra >= 5'd20) return 32'h0;
    if (ra == 5'd0) return 32'h0;
    if (we_c && (waddr_c == ra)) return {16'h0, wdata_c};
    return {16'h0, model_c[ra]};
  endfunction

  task automatic expect_const(input string tag, input int unsigned sel, input logic [31:0] exp);
    sb_t e;
    e.tag = tag; e.sel = sel; e.exp = exp;
    sb_q.push_back(e);
  endtask

  // Push model expectations for all six outputs, compare mid-cycle, then clock the model.
  task automatic step(input string tag);
    expect_const({tag, ".a0"}, 0, ref_ab(ra0_ab, 1'b1));
    expect_const({tag, ".a1"}, 1, ref_ab(ra1_ab, 1'b1));
    expect_const({tag, ".b0"}, 2, ref_ab(ra0_ab, 1'b0));
    expect_const({tag, ".b1"}, 3, ref_ab(ra1_ab, 1'b0));
    expect_const({tag, ".c0"}, 4, ref_c(ra0_c));
    expect_const({tag, ".c1"}, 5, ref_c(ra1_c));
    @(negedge clk);
    while (sb_q.size() > 0) begin
      sb_t e;
      e = sb_q.pop_front();
      check_val(e.tag, dut_out(e.sel), e.exp);
    end
    @(posedge clk);
    if (rst) begin
      foreach (model_ab[i]) model_ab[i] = 32'h0;
      foreach (model_c[i])  model_c[i]  = 16'h0;
    end else begin
      if (we_ab && (waddr_ab != 5'd0)) model_ab[waddr_ab] = wdata_ab;
      if (we_c && (waddr_c < 5'd20) && (waddr_c != 5'd0)) model_c[waddr_c] = wdata_c;
    end
    #1;
  endtask

  initial begin
    foreach (model_ab[i]) model_ab[i] = 32'h0;
    foreach (model_c[i])  model_c[i]  = 16'h0;
    rst = 1'b1; we_ab = 1'b0; waddr_ab = '0; wdata_ab = '0; ra0_ab = 5'd3; ra1_ab = 5'd9;
    we_c = 1'b0; waddr_c = '0; wdata_c = '0; ra0_c = 5'd1; ra1_c = 5'd19;
    expect_const("init_rst.a0", 0, 32'h0);
    expect_const("init_rst.c1", 5, 32'h0);
    step("init");
    step("init2");
    rst = 1'b0;

    // Reset clears a written entry; outputs forced to zero during reset.
    we_ab = 1'b1; waddr_ab = 5'd5; wdata_ab = 32'hDEADBEEF; ra0_ab = 5'd5; ra1_ab = 5'd5;
    step("wr5");
    we_ab = 1'b0;
    expect_const("rd5_val", 0, 32'hDEADBEEF);
    step("rd5");
    rst = 1'b1;
    expect_const("rst_cyc0", 0, 32'h0);
    expect_const("rst_cyc1", 1, 32'h0);
    step("rst_cyc");
    rst = 1'b0;
    expect_const("rd5_cleared", 0, 32'h0);
    step("rd5_after_rst");

    // Fill entries 1..31 then read mirrored pairs.
    for (int i = 1; i < 32; i++) begin
      we_ab = 1'b1; waddr_ab = 5'(i); wdata_ab = 32'hA5A50000 + 32'(i);
      ra0_ab = 5'(i); ra1_ab = 5'(i - 1);
      step("fill");
    end
    we_ab = 1'b1; waddr_ab = 5'd0; wdata_ab = 32'hFFFFFFFF; ra0_ab = 5'd0; ra1_ab = 5'd0;
    expect_const("zero_byp", 0, 32'h0);
    step("wr0");
    we_ab = 1'b0;
    for (int i = 0; i < 32; i++) begin
      ra0_ab = 5'(i); ra1_ab = 5'(31 - i);
      expect_const("pair0", 0, (i == 0) ? 32'h0 : 32'hA5A50000 + 32'(i));
      expect_const("pair1", 1, (i == 31) ? 32'h0 : 32'hA5A50000 + 32'(31 - i));
      step("pairs");
    end

    // Bypass vs. no-bypass on a same-cycle write.
    we_ab = 1'b1; waddr_ab = 5'd7; wdata_ab = 32'h11111111;
    step("wr7a");
    wdata_ab = 32'h22222222; ra0_ab = 5'd7; ra1_ab = 5'd7;
    expect_const("byp_a0", 0, 32'h22222222);
    expect_const("byp_a1", 1, 32'h22222222);
    expect_const("nobyp_b0", 2, 32'h11111111);
    expect_const("nobyp_b1", 3, 32'h11111111);
    step("wr7b");
    we_ab = 1'b0;
    expect_const("post_b0", 2, 32'h22222222);
    expect_const("post_b1", 3, 32'h22222222);
    step("rd7");

    // Hold: idle cycles with garbage address/data must not disturb storage.
    we_ab = 1'b1; waddr_ab = 5'd3; wdata_ab = 32'h0000CAFE;
    step("wr3");
    for (int i = 0; i < 10; i++) begin
      we_ab = 1'b0; waddr_ab = 5'($urandom_range(0, 31)); wdata_ab = $urandom;
      ra0_ab = 5'($urandom_range(0, 31)); ra1_ab = 5'($urandom_range(0, 31));
      we_c = 1'b0; waddr_c = 5'($urandom_range(0, 31)); wdata_c = 16'($urandom);
      step("hold");
    end
    ra0_ab = 5'd3; ra1_ab = 5'd3;
    expect_const("hold3", 0, 32'h0000CAFE);
    step("hold3");
    for (int i = 0; i < 32; i += 2) begin
      ra0_ab = 5'(i); ra1_ab = 5'(i + 1);
      step("hold_scan");
    end

    // Non-power-of-two depth: out-of-range write/read and top entry.
    we_c = 1'b1; waddr_c = 5'd25; wdata_c = 16'hBEEF; ra0_c = 5'd25; ra1_c = 5'd25;
    expect_const("c_oor_byp", 4, 32'h0);
    step("c_wr25");
    we_c = 1'b0;
    expect_const("c_rd25", 4, 32'h0);
    step("c_rd25");
    we_c = 1'b1; waddr_c = 5'd19; wdata_c = 16'h1234; ra0_c = 5'd19; ra1_c = 5'd18;
    step("c_wr19");
    we_c = 1'b0;
    expect_const("c_rd19", 4, 32'h00001234);
    step("c_rd19");

    // Reset/write collision drops the write; the next write lands.
    rst = 1'b1; we_ab = 1'b1; waddr_ab = 5'd4; wdata_ab = 32'h55AA55AA; ra0_ab = 5'd4; ra1_ab = 5'd4;
    step("coll");
    rst = 1'b0; we_ab = 1'b0;
    expect_const("coll_lost", 0, 32'h0);
    step("coll_rd");
    we_ab = 1'b1;
    step("coll_wr");
    we_ab = 1'b0;
    expect_const("coll_next", 0, 32'h55AA55AA);
    step("coll_rd2");

    // Random mix on all builds.
    for (int i = 0; i < 60; i++) begin
      we_ab = 1'($urandom); waddr_ab = 5'($urandom_range(0, 31)); wdata_ab = $urandom;
      ra0_ab = ($urandom_range(0, 3) == 0) ? waddr_ab : 5'($urandom_range(0, 31));
      ra1_ab = 5'($urandom_range(0, 31));
      we_c = 1'($urandom); waddr_c = 5'($urandom_range(0, 31)); wdata_c = 16'($urandom);
      ra0_c = ($urandom_range(0, 3) == 0) ? waddr_c : 5'($urandom_range(0, 31));
      ra1_c = 5'($urandom_range(0, 31));
      step("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
